alu_result_stage: RTL and testbench

//   Registered ALU stage built around the 32-bit element ops (and32, or32, add32, ...).

---
 rtl/alu_result_stage.sv | 117 +++++++++++
 tb/tb_alu_result_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered ALU stage: computes one 32-bit ALU operation per accepted operand pair
// and buffers the result and its zero/overflow flags in a 2-entry FIFO, so a stalled
// writeback consumer never loses a result. in_ready depends only on registered state.

module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       count
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_zero;

  logic [WIDTH-1:0] mem_res [0:1];
  logic [1:0]       mem_zero;
  logic [1:0]       mem_ovf;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign sum  = A + B;
  assign diff = A - B;

  // Combinational ALU: result and signed-overflow flag for the presented operands
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALU_operation)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: alu_res = ~(A | B);
      OP_XOR: alu_res = A ^ B;
      OP_SRL: alu_res = B >> A[4:0];
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Handshake: full blocks pushes even if the head is popped this cycle
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head of the FIFO drives the outputs; storage is cleared on reset so they read 0
  assign res      = mem_res[rd_ptr];
  assign zero     = mem_zero[rd_ptr];
  assign overflow = mem_ovf[rd_ptr];

  // FIFO storage, pointers and occupancy; reset discards any buffered results
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_res[0] <= '0;
      mem_res[1] <= '0;
      mem_zero   <= '0;
      mem_ovf    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        mem_res[wr_ptr]  <= alu_res;
        mem_zero[wr_ptr] <= alu_zero;
        mem_ovf[wr_ptr]  <= alu_ovf;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Directed plus randomized stimulus against a queue-based reference of the stage.

module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  ALU_operation = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        zero;
  logic        overflow;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;
  logic [33:0] q[$];
  bit afterReset = 1'b0;

  alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_operation(ALU_operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the operation table with plain integer arithmetic
  function automatic logic [33:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    longint sa, sb, wide;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        wide = sa + sb;
        r = 32'(wide);
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'b110: begin
        wide = sa - sb;
        r = 32'(wide);
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      3'b100: r = ~(a | b);
      3'b011: r = a ^ b;
      default: r = b / (32'd1 << a[4:0]);
    endcase
    return {r, (r == 32'd0), ov};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with what the reference queue implies
  task automatic checkOutput();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    if (q.size() != 0) begin
      chk("res", res, q[0][33:2]);
      chk("zero", 32'(zero), 32'(q[0][1]));
      chk("overflow", 32'(overflow), 32'(q[0][0]));
    end else if (afterReset) begin
      chk("reset_res", res, 32'd0);
      chk("reset_zero", 32'(zero), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
    end
    afterReset = 1'b0;
  endtask

  // One cycle: check, drive inputs, then advance the reference at the clock edge
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic ordy);
    bit acc, pp;
    @(negedge clk);
    checkOutput();
    in_valid = v; A = a; B = b; ALU_operation = op; out_ready = ordy;
    @(posedge clk);
    acc = v && (q.size() != 2);
    pp  = (q.size() != 0) && ordy;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(refAlu(a, b, op));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; A = $urandom; B = $urandom;
    ALU_operation = 3'b010; out_ready = 1'b0;
    @(posedge clk);
    q.delete();
    afterReset = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checkOutput();
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    doReset();

    applyStimulus(1, 32'h0000FFFF, 32'h00FF00FF, 3'b000, 1);
    applyStimulus(1, 32'h7FFFFFFF, 32'd1, 3'b010, 1);
    applyStimulus(1, 32'd5, 32'd5, 3'b110, 1);
    applyStimulus(1, 32'hFFFFFFFF, 32'd1, 3'b111, 1);
    applyStimulus(1, 32'd4, 32'hF0000000, 3'b101, 1);
    applyStimulus(1, 32'd0, 32'd0, 3'b100, 1);
    applyStimulus(1, 32'h80000000, 32'd1, 3'b110, 1);
    applyStimulus(1, 32'h80000000, 32'h7FFFFFFF, 3'b111, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);

    applyStimulus(1, 32'h12345678, 32'h0F0F0F0F, 3'b011, 0);
    applyStimulus(1, 32'hA0000000, 32'h0000000F, 3'b001, 0);
    applyStimulus(1, 32'h00000003, 32'h00000003, 3'b010, 0);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 0);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);

    applyStimulus(1, 32'd10, 32'd20, 3'b010, 0);
    applyStimulus(1, 32'd7, 32'd9, 3'b110, 1);
    applyStimulus(1, 32'd31, 32'h80000000, 3'b101, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);

    applyStimulus(1, 32'h11111111, 32'h22222222, 3'b010, 0);
    applyStimulus(1, 32'h33333333, 32'h44444444, 3'b010, 0);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 0);
    doReset();
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) doReset();
      applyStimulus(1'($urandom_range(0, 3) != 0), randOperand(), randOperand(),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 1);
    @(negedge clk);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
